// File: rtl/packet_route_pkg.sv
// rtl/packet_route_pkg.sv - shared types and helpers for the packet route demux
package packet_route_pkg;

    // One-hot FSM encoding; the held destination lives outside the state.
    typedef enum logic [2:0] {
        IDLE  = 3'b001,
        ROUTE = 3'b010,
        DROP  = 3'b100
    } state_e;

    // True when a destination index addresses an existing output port.
    function automatic logic sel_in_range(input logic [31:0] sel, input int unsigned n);
        return sel < n;
    endfunction

endpackage

// File: rtl/stream_out_reg.sv
// rtl/stream_out_reg.sv - one-entry output holding register with pass-through load and flush
module stream_out_reg #(
    parameter type         DataType = logic,
    parameter int unsigned SelW     = 2
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            flush_i,
    input  logic            load_i,
    input  logic [SelW-1:0] load_sel_i,
    input  DataType         load_data_i,
    input  logic            drain_i,
    output logic            vld_o,
    output logic [SelW-1:0] sel_o,
    output DataType         data_o,
    output logic            free_o
);

    logic            vld_q, vld_d;
    logic [SelW-1:0] sel_q, sel_d;
    DataType         data_q, data_d;

    // drain_i is the ready of the port currently addressed by sel_q.
    assign free_o = !vld_q || drain_i;
    assign vld_o  = vld_q;
    assign sel_o  = sel_q;
    assign data_o = data_q;

    // Next entry: flush empties, a load replaces (possibly while draining), a lone drain empties.
    always_comb begin
        vld_d  = vld_q;
        sel_d  = sel_q;
        data_d = data_q;
        if (flush_i) begin
            vld_d = 1'b0;
        end else if (load_i) begin
            vld_d  = 1'b1;
            sel_d  = load_sel_i;
            data_d = load_data_i;
        end else if (vld_q && drain_i) begin
            vld_d = 1'b0;
        end
    end

    // Entry registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            vld_q  <= 1'b0;
            sel_q  <= '0;
            data_q <= '0;
        end else begin
            vld_q  <= vld_d;
            sel_q  <= sel_d;
            data_q <= data_d;
        end
    end

endmodule

// File: rtl/packet_route_demux.sv
// rtl/packet_route_demux.sv - packet-locked 1-to-NumOut stream demultiplexer
module packet_route_demux
    import packet_route_pkg::*;
#(
    parameter int unsigned NumOut   = 4,
    parameter type         DataType = logic,
    localparam int unsigned SelW    = $clog2(NumOut)
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   flush_i,
    input  logic                   req_i,
    input  DataType                data_i,
    input  logic [SelW-1:0]        sel_i,
    input  logic                   last_i,
    output logic                   gnt_o,
    output logic [NumOut-1:0]      req_o,
    output DataType [NumOut-1:0]   data_o,
    input  logic [NumOut-1:0]      gnt_i,
    output logic                   busy_o,
    output logic                   err_o
);

    state_e          state_q, state_d;
    logic [SelW-1:0] lock_sel_q, lock_sel_d;
    logic            err_q, err_d;

    logic            load;
    logic [SelW-1:0] load_sel;
    logic            out_vld;
    logic [SelW-1:0] out_sel;
    DataType         out_data;
    logic            out_ready;
    logic            slot_free;
    logic            xfer;

    stream_out_reg #(
        .DataType (DataType),
        .SelW     (SelW)
    ) u_out_reg (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .flush_i     (flush_i),
        .load_i      (load),
        .load_sel_i  (load_sel),
        .load_data_i (data_i),
        .drain_i     (out_ready),
        .vld_o       (out_vld),
        .sel_o       (out_sel),
        .data_o      (out_data),
        .free_o      (slot_free)
    );

    // Ready of the port the held beat is addressed to.
    always_comb begin
        out_ready = 1'b0;
        for (int unsigned j = 0; j < NumOut; j++) begin
            if (32'(out_sel) == j) begin
                out_ready = gnt_i[j];
            end
        end
    end

    // DROP sinks beats regardless of the output slot; otherwise wait for a free slot.
    assign gnt_o  = !flush_i && ((state_q == DROP) || slot_free);
    assign xfer   = req_i && gnt_o;
    assign busy_o = (state_q != IDLE) || out_vld;
    assign err_o  = err_q;

    // Packet FSM: sample the destination on the first beat, hold it until last is accepted.
    always_comb begin
        state_d    = state_q;
        lock_sel_d = lock_sel_q;
        err_d      = 1'b0;
        load       = 1'b0;
        load_sel   = sel_i;
        if (flush_i) begin
            state_d = IDLE;
        end else if (xfer) begin
            case (state_q)
                IDLE: begin
                    if (sel_in_range(32'(sel_i), NumOut)) begin
                        load = 1'b1;
                        if (!last_i) begin
                            lock_sel_d = sel_i;
                            state_d    = ROUTE;
                        end
                    end else begin
                        err_d = 1'b1;
                        if (!last_i) begin
                            state_d = DROP;
                        end
                    end
                end
                ROUTE: begin
                    load     = 1'b1;
                    load_sel = lock_sel_q;
                    if (last_i) begin
                        state_d = IDLE;
                    end
                end
                DROP: begin
                    if (last_i) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // FSM, destination lock and error pulse registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            lock_sel_q <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            lock_sel_q <= lock_sel_d;
            err_q      <= err_d;
        end
    end

    // Per-port decode: only the addressed port sees valid and payload.
    always_comb begin
        req_o  = '0;
        data_o = '0;
        for (int unsigned j = 0; j < NumOut; j++) begin
            if (32'(out_sel) == j) begin
                req_o[j]  = out_vld;
                data_o[j] = out_data;
            end
        end
    end

endmodule

// File: tb/tb_packet_route_demux.sv
// tb/tb_packet_route_demux.sv - self-checking bench for packet_route_demux
module tb_packet_route_demux;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic            flush4, req4, last4, gnt_o4, busy4, err4;
    logic [7:0]      data4;
    logic [1:0]      sel4;
    logic [3:0]      gnt4, req_o4;
    logic [3:0][7:0] data_o4;

    logic            flush3, req3, last3, gnt_o3, busy3, err3;
    logic [7:0]      data3;
    logic [1:0]      sel3;
    logic [2:0]      gnt3, req_o3;
    logic [2:0][7:0] data_o3;

    packet_route_demux #(.NumOut(4), .DataType(logic [7:0])) u_dut4 (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush4), .req_i(req4), .data_i(data4),
        .sel_i(sel4), .last_i(last4), .gnt_o(gnt_o4), .req_o(req_o4), .data_o(data_o4),
        .gnt_i(gnt4), .busy_o(busy4), .err_o(err4)
    );

    packet_route_demux #(.NumOut(3), .DataType(logic [7:0])) u_dut3 (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush3), .req_i(req3), .data_i(data3),
        .sel_i(sel3), .last_i(last3), .gnt_o(gnt_o3), .req_o(req_o3), .data_o(data_o3),
        .gnt_i(gnt3), .busy_o(busy3), .err_o(err3)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    // Scoreboard for the 4-port instance: expected {port, data} in delivery order.
    typedef struct packed {
        logic [1:0] port;
        logic [7:0] data;
    } exp_t;

    exp_t       sb[$];
    exp_t       sb_e;
    logic       m_route;
    logic [1:0] m_lock;
    logic [1:0] m_port;

    always @(negedge clk) begin
        if (!rst_n) begin
            sb.delete();
            m_route = 1'b0;
        end else begin
            for (int j = 0; j < 4; j++) begin
                if (req_o4[j] && gnt4[j]) begin
                    if (sb.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL sb_extra: port %0d delivered %0h, required no beat", j, data_o4[j]);
                    end else begin
                        sb_e = sb.pop_front();
                        check("sb_port", 32'(j), 32'(sb_e.port));
                        check("sb_data", 32'(data_o4[j]), 32'(sb_e.data));
                    end
                end
            end
            if (flush4) begin
                sb.delete();
                m_route = 1'b0;
            end else if (req4 && gnt_o4) begin
                m_port = m_route ? m_lock : sel4;
                if (!m_route && !last4) begin
                    m_lock  = sel4;
                    m_route = 1'b1;
                end else if (m_route && last4) begin
                    m_route = 1'b0;
                end
                sb.push_back({m_port, data4});
            end
        end
    end

    typedef struct {
        logic       req;
        logic [1:0] sel;
        logic       last;
        logic [7:0] data;
        logic [3:0] gnt;
        logic       flush;
        logic [3:0] e_req;
        logic [7:0] e_data;
        logic       e_gnt;
        logic       e_busy;
        logic       e_err;
    } vec_t;

    function automatic vec_t mk(input logic req, input logic [1:0] sel, input logic last,
                                input logic [7:0] data, input logic [3:0] gnt, input logic flush,
                                input logic [3:0] e_req, input logic [7:0] e_data,
                                input logic e_gnt, input logic e_busy, input logic e_err);
        vec_t v;
        v.req = req; v.sel = sel; v.last = last; v.data = data; v.gnt = gnt; v.flush = flush;
        v.e_req = e_req; v.e_data = e_data; v.e_gnt = e_gnt; v.e_busy = e_busy; v.e_err = e_err;
        return v;
    endfunction

    vec_t vecs[22];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        // 3-beat packet to port 2, sel changes on beats 2-3 ignored
        vecs[0]  = mk(1, 2, 0, 8'h0A, 4'hF, 0, 4'b0000, 8'h00, 1, 0, 0);
        vecs[1]  = mk(1, 0, 0, 8'h0B, 4'hF, 0, 4'b0100, 8'h0A, 1, 1, 0);
        vecs[2]  = mk(1, 0, 1, 8'h0C, 4'hF, 0, 4'b0100, 8'h0B, 1, 1, 0);
        // back-to-back: 2 beats to port 1 then 1 beat to port 3
        vecs[3]  = mk(1, 1, 0, 8'h11, 4'hF, 0, 4'b0100, 8'h0C, 1, 1, 0);
        vecs[4]  = mk(1, 3, 1, 8'h12, 4'hF, 0, 4'b0010, 8'h11, 1, 1, 0);
        vecs[5]  = mk(1, 3, 1, 8'h31, 4'hF, 0, 4'b0010, 8'h12, 1, 1, 0);
        vecs[6]  = mk(0, 0, 0, 8'h00, 4'hF, 0, 4'b1000, 8'h31, 1, 1, 0);
        vecs[7]  = mk(0, 0, 0, 8'h00, 4'hF, 0, 4'b0000, 8'h00, 1, 0, 0);
        // backpressure on port 1 for three cycles mid-packet
        vecs[8]  = mk(1, 1, 0, 8'h41, 4'hF, 0, 4'b0000, 8'h00, 1, 0, 0);
        vecs[9]  = mk(1, 1, 0, 8'h42, 4'hD, 0, 4'b0010, 8'h41, 0, 1, 0);
        vecs[10] = mk(1, 1, 0, 8'h42, 4'hD, 0, 4'b0010, 8'h41, 0, 1, 0);
        vecs[11] = mk(1, 1, 0, 8'h42, 4'hD, 0, 4'b0010, 8'h41, 0, 1, 0);
        vecs[12] = mk(1, 1, 0, 8'h42, 4'hF, 0, 4'b0010, 8'h41, 1, 1, 0);
        vecs[13] = mk(1, 1, 1, 8'h43, 4'hF, 0, 4'b0010, 8'h42, 1, 1, 0);
        vecs[14] = mk(0, 0, 0, 8'h00, 4'hF, 0, 4'b0010, 8'h43, 1, 1, 0);
        vecs[15] = mk(0, 0, 0, 8'h00, 4'hF, 0, 4'b0000, 8'h00, 1, 0, 0);
        // flush with a held beat on port 0, then a fresh packet to port 2
        vecs[16] = mk(1, 0, 0, 8'h51, 4'hF, 0, 4'b0000, 8'h00, 1, 0, 0);
        vecs[17] = mk(0, 0, 0, 8'h00, 4'hE, 0, 4'b0001, 8'h51, 0, 1, 0);
        vecs[18] = mk(0, 0, 0, 8'h00, 4'hE, 1, 4'b0001, 8'h51, 0, 1, 0);
        vecs[19] = mk(1, 2, 1, 8'h52, 4'hF, 0, 4'b0000, 8'h00, 1, 0, 0);
        vecs[20] = mk(0, 0, 0, 8'h00, 4'hF, 0, 4'b0100, 8'h52, 1, 1, 0);
        vecs[21] = mk(0, 0, 0, 8'h00, 4'hF, 0, 4'b0000, 8'h00, 1, 0, 0);

        rst_n = 1'b0;
        flush4 = 0; req4 = 0; last4 = 0; data4 = 0; sel4 = 0; gnt4 = 4'hF;
        flush3 = 0; req3 = 0; last3 = 0; data3 = 0; sel3 = 0; gnt3 = 3'h7;
        repeat (2) @(posedge clk);
        #1;
        check("rst_req_o4", 32'(req_o4), 0);
        check("rst_data_o4", 32'(data_o4), 0);
        check("rst_gnt_o4", 32'(gnt_o4), 1);
        check("rst_busy4", 32'(busy4), 0);
        check("rst_err4", 32'(err4), 0);
        check("rst_req_o3", 32'(req_o3), 0);
        check("rst_gnt_o3", 32'(gnt_o3), 1);
        rst_n = 1'b1;

        for (int i = 0; i < 22; i++) begin
            @(posedge clk);
            #1;
            req4 = vecs[i].req; sel4 = vecs[i].sel; last4 = vecs[i].last;
            data4 = vecs[i].data; gnt4 = vecs[i].gnt; flush4 = vecs[i].flush;
            @(negedge clk);
            check($sformatf("row%0d_req_o", i), 32'(req_o4), 32'(vecs[i].e_req));
            check($sformatf("row%0d_gnt_o", i), 32'(gnt_o4), 32'(vecs[i].e_gnt));
            check($sformatf("row%0d_busy", i), 32'(busy4), 32'(vecs[i].e_busy));
            check($sformatf("row%0d_err", i), 32'(err4), 32'(vecs[i].e_err));
            for (int j = 0; j < 4; j++) begin
                if (vecs[i].e_req[j]) begin
                    check($sformatf("row%0d_data_o", i), 32'(data_o4[j]), 32'(vecs[i].e_data));
                end
            end
        end

        // Out-of-range destination on the 3-port instance: 2-beat packet to port 3
        @(posedge clk); #1;
        req3 = 1; sel3 = 3; last3 = 0; data3 = 8'h61;
        @(negedge clk);
        check("oor_c0_gnt", 32'(gnt_o3), 1);
        check("oor_c0_err", 32'(err3), 0);
        @(posedge clk); #1;
        sel3 = 0; last3 = 1; data3 = 8'h62;
        @(negedge clk);
        check("oor_c1_err", 32'(err3), 1);
        check("oor_c1_req", 32'(req_o3), 0);
        check("oor_c1_gnt", 32'(gnt_o3), 1);
        check("oor_c1_busy", 32'(busy3), 1);
        @(posedge clk); #1;
        req3 = 0;
        @(negedge clk);
        check("oor_c2_err", 32'(err3), 0);
        check("oor_c2_req", 32'(req_o3), 0);
        check("oor_c2_busy", 32'(busy3), 0);
        @(posedge clk); #1;
        req3 = 1; sel3 = 1; last3 = 1; data3 = 8'h63;
        @(negedge clk);
        check("oor_c3_gnt", 32'(gnt_o3), 1);
        @(posedge clk); #1;
        req3 = 0;
        @(negedge clk);
        check("oor_c4_req", 32'(req_o3), 32'(3'b010));
        check("oor_c4_data", 32'(data_o3[1]), 32'h63);
        check("oor_c4_err", 32'(err3), 0);

        // Asynchronous reset in the middle of a packet to port 3
        @(posedge clk); #1;
        req4 = 1; sel4 = 3; last4 = 0; data4 = 8'h71; gnt4 = 4'hF;
        @(negedge clk);
        @(posedge clk); #1;
        data4 = 8'h72;
        @(negedge clk);
        check("rstm_req_before", 32'(req_o4), 32'(4'b1000));
        #2;
        rst_n = 1'b0;
        req4 = 0;
        #1;
        check("rstm_req_o", 32'(req_o4), 0);
        check("rstm_data_o", 32'(data_o4), 0);
        check("rstm_busy", 32'(busy4), 0);
        check("rstm_err", 32'(err4), 0);
        check("rstm_gnt", 32'(gnt_o4), 1);
        @(posedge clk);
        @(posedge clk); #1;
        rst_n = 1'b1;
        req4 = 1; sel4 = 0; last4 = 1; data4 = 8'h73;
        @(negedge clk);
        check("rstm_after_gnt", 32'(gnt_o4), 1);
        check("rstm_after_req", 32'(req_o4), 0);
        @(posedge clk); #1;
        req4 = 0;
        @(negedge clk);
        check("rstm_first_req", 32'(req_o4), 32'(4'b0001));
        check("rstm_first_data", 32'(data_o4[0]), 32'h73);
        @(posedge clk); #1;
        @(negedge clk);
        check("sb_drained", 32'(sb.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
